// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one external memory between the CPU and an AUX master.
// Round-robin on ties by default; define MEM_ARB_CPU_PRIO_EN for fixed CPU priority.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_adr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LAT);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
    logic              pick_aux;
    logic              capture;

    // pick_aux is only consulted while at least one request is pending.
`ifdef MEM_ARB_CPU_PRIO_EN
    assign pick_aux = !cpu_req;
`else
    assign pick_aux = aux_req && (!cpu_req || !owner_q);
`endif

    // NOTE: every state register is reset asynchronously and updated with <= only,
    // so reset drops the ACCESS-qualified mem_we without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b1;
            cnt_q       <= 2'd0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    // NOTE: all next-state values default to their current value first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || aux_req) begin
                    owner_d = pick_aux;
                    we_d    = pick_aux ? aux_we    : cpu_we;
                    adr_d   = pick_aux ? aux_adr   : cpu_adr;
                    wdata_d = pick_aux ? aux_wdata : cpu_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (READ_LAT == 0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            if (owner_q) begin
                aux_rdata_d = mem_rdata;
            end else begin
                cpu_rdata_d = mem_rdata;
            end
        end
    end

    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == DONE) && !owner_q;
    assign aux_ack   = (state_q == DONE) && owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign aux_rdata = aux_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single byte-wide external memory between the MIPS core (CPU port) and an auxiliary requester (AUX port: program loader / debug / DMA).
- Sits between mips, the aux master and memory. Owns the memory's write-enable, address and write-data pins.
- Serialises whole transactions with a req/ack handshake per port. Round-robin arbitration by default.

Parameters:
- ADDR_W, 8, address width of both ports and the memory.
- DATA_W, 8, data width of both ports and the memory.
- READ_LAT, 1, cycles from mem_adr driven to mem_rdata valid. Legal range 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU transaction request. Level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Sampled at grant.
- cpu_adr  in  ADDR_W  CPU address. Sampled at grant.
- cpu_wdata  in  DATA_W  CPU write data. Sampled at grant.
- cpu_rdata  out  DATA_W  CPU read data. Registered.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- aux_req, aux_we, aux_adr, aux_wdata, aux_rdata, aux_ack  same as the CPU port, for the AUX requester.
- mem_we  out  1  memory write enable.
- mem_adr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  0 = CPU, 1 = AUX. Holds the last granted port.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - mem_we=0, mem_adr=0, mem_wdata=0.
  - cpu_ack=aux_ack=0, cpu_rdata=aux_rdata=0, busy=0.
  - owner=1, so the CPU wins the first tie.
  - Asserting reset during ACCESS drops mem_we immediately. No ack is issued for the aborted transaction.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high, pick a winner and latch its we/adr/wdata into internal registers. Update owner, go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one request: grant it.
  - Both requests: grant the port that is not equal to owner (round-robin).
- ACCESS (exactly 1 cycle):
  - mem_adr and mem_wdata are driven from the latched values. mem_we equals the latched we in this cycle only.
  - Write: go to DONE.
  - Read with READ_LAT=0: capture mem_rdata into the owner's rdata register, go to DONE.
  - Read with READ_LAT>0: go to WAIT with the counter loaded to READ_LAT.
- WAIT:
  - mem_adr is held and mem_we=0. The counter decrements each cycle.
  - In the cycle the counter reaches 1, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE (1 cycle):
  - The owner's ack=1. Its rdata is valid from this cycle and holds until that port's next read completes.
  - Go to IDLE.
- Latency, measured from the IDLE grant cycle = cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+READ_LAT.
  - Minimum spacing between grants is 3 cycles.
- Requester rules:
  - A req still high in the IDLE cycle after DONE counts as a new request. Back-to-back requests are legal.
  - If a req drops mid-transaction, the transaction still completes on the latched values and ack still pulses.
- Changes to non-owner inputs have no effect on an in-flight transaction.
- A write never updates either rdata register.
- Address/data are passed unmodified. No wrap-around arithmetic is performed.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. cpu_req always wins a tie; AUX is granted only when cpu_req=0 in IDLE. owner still updates on every grant.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then cpu_req write adr=0x10 wdata=0xA5 (READ_LAT=1) -> mem_we=1 with mem_adr=0x10, mem_wdata=0xA5 in cycle 1 only; cpu_ack in cycle 2; aux_ack stays 0.
- Follow with cpu_req read adr=0x10, memory returns 0xA5 -> cpu_ack in cycle 3; cpu_rdata=0xA5 from cycle 3 and held after; aux_rdata=0x00.
- cpu_req and aux_req raised together and both held high for 4 transactions after reset -> grants alternate CPU, AUX, CPU, AUX; with MEM_ARB_CPU_PRIO_EN -> CPU, CPU, CPU, CPU.
- aux_req write adr=0x20 wdata=0x3C, with aux_req dropped and aux_adr changed to 0xFF in cycle 1 -> write still goes to 0x20; aux_ack still pulses in cycle 2.
- reset asserted mid-ACCESS of a write -> mem_we falls in the same cycle, no ack, busy=0; memory location is unchanged.
- READ_LAT=0 and READ_LAT=3 builds, read of adr=0x05 holding 0x77 -> cpu_ack at cycle 2 and cycle 5 respectively; cpu_rdata=0x77 in both.
